// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative signed multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    // Widest operand the unit supports; sizes the overflow-test argument.
    localparam int unsigned MAX_WIDTH = 64;

    // True when the signed 2*width-bit product in prod[2*width-1:0] is representable
    // in width bits, i.e. bits [2*width-1:width-1] are all equal.
    function automatic logic sat_fits(input logic [2*MAX_WIDTH-1:0] prod,
                                      input int unsigned width);
        logic signed [2*MAX_WIDTH-1:0] top;
        logic signed [2*MAX_WIDTH-1:0] ext;
        // Move bit 2*width-1 to the MSB, then keep only the top width+1 bits, sign-extended.
        top = prod << (2 * MAX_WIDTH - 2 * width);
        ext = top >>> (2 * MAX_WIDTH - width - 1);
        return (ext == '0) || (&ext);
    endfunction

endpackage

// File: rtl/abs_neg.sv
// Combinational conditional two's-complement negate (magnitude or sign application).
module abs_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/multdiv_iter.sv
// Iterative radix-2 signed multiply / restoring divide, one step per clock.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               sign_q, sign_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;       // MULT: {partial, multiplier}; DIV: {rem, quotient}
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic               start;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] res_mag, res_signed;
    logic [2*MAX_WIDTH-1:0] prod_ext;

    // Exactly one control high is a start; both high is ignored.
    assign start = ctrl_MULT ^ ctrl_DIV;

    abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (data_operandA),
        .neg_i (data_operandA[WIDTH-1]),
        .res_o (a_mag)
    );

    abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (data_operandB),
        .neg_i (data_operandB[WIDTH-1]),
        .res_o (b_mag)
    );

    abs_neg #(.WIDTH(2 * WIDTH)) u_sign_res (
        .val_i (res_mag),
        .neg_i (sign_q),
        .res_o (res_signed)
    );

    // Single-step datapath for both operations, plus the signed-result staging.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[WIDTH];   // no borrow: divisor fits into partial remainder
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

        res_mag  = (op_q == OP_MULT) ? acc_q : {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        prod_ext = '0;
        prod_ext[2*WIDTH-1:0] = res_signed;
    end

    // Next-state and output-register logic; a start pre-empts whatever the FSM was doing.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        div0_d   = div0_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        unique case (state_q)
            IDLE: ;
            RUN: begin
                acc_d = (op_q == OP_MULT) ? mul_next : div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
                if (op_q == OP_MULT) begin
                    result_d = res_signed[WIDTH-1:0];
                    exc_d    = ~sat_fits(prod_ext, WIDTH);
                end else if (div0_q) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    result_d = res_signed[WIDTH-1:0];
                    // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1.
                    exc_d    = ~sign_q & acc_q[WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d  = RUN;
            op_d     = ctrl_DIV ? OP_DIV : OP_MULT;
            sign_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div0_d   = (data_operandB == '0);
            opnd_d   = ctrl_DIV ? b_mag : a_mag;
            acc_d    = {{WIDTH{1'b0}}, (ctrl_DIV ? a_mag : b_mag)};
            cnt_d    = '0;
            result_d = result_q;
            exc_d    = exc_q;
            rdy_d    = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            sign_q   <= 1'b0;
            div0_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            div0_q   <= div0_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter: a 32-bit and an 8-bit instance against an arithmetic model.
module tb_multdiv_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m32, d32, m8, d8;
    logic [31:0] a32, b32, r32;
    logic [7:0]  a8, b8, r8;
    logic        e32, e8, rdy32, rdy8, busy32, busy8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multdiv_iter #(.WIDTH(32)) dut32 (
        .clock          (clk),
        .reset          (reset),
        .ctrl_MULT      (m32),
        .ctrl_DIV       (d32),
        .data_operandA  (a32),
        .data_operandB  (b32),
        .data_result    (r32),
        .data_exception (e32),
        .data_resultRDY (rdy32),
        .busy           (busy32)
    );

    multdiv_iter #(.WIDTH(8)) dut8 (
        .clock          (clk),
        .reset          (reset),
        .ctrl_MULT      (m8),
        .ctrl_DIV       (d8),
        .data_operandA  (a8),
        .data_operandB  (b8),
        .data_result    (r8),
        .data_exception (e8),
        .data_resultRDY (rdy8),
        .busy           (busy8)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- model: pure arithmetic + an edge countdown ----------------
    function automatic longint sx(input logic [63:0] v, input int w);
        longint t;
        t = longint'(v);
        t = t <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    task automatic model_op(input bit is_div, input logic [63:0] a, input logic [63:0] b,
                            input int w, output logic [63:0] res, output bit exc);
        longint sa, sb, r, lo, hi;
        logic [63:0] mask;
        sa   = sx(a, w);
        sb   = sx(b, w);
        lo   = -(longint'(1) <<< (w - 1));
        hi   = (longint'(1) <<< (w - 1)) - 1;
        mask = (64'd1 << w) - 64'd1;
        if (!is_div) begin
            r   = sa * sb;
            exc = (r < lo) || (r > hi);
        end else if (sb == 0) begin
            r   = 0;
            exc = 1'b1;
        end else begin
            r   = sa / sb;
            exc = (r > hi);
        end
        res = logic'(1'b0) ? 64'd0 : (64'(r) & mask);
    endtask

    int          pend [2];
    logic [63:0] pres [2];
    bit          pexc [2];
    logic [63:0] eres [2];
    bit          eexc [2];
    bit          erdy [2];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit          m, d;
            logic [63:0] a, b;
            int          w;
            if (i == 0) begin
                m = m32; d = d32; a = 64'(a32); b = 64'(b32); w = 32;
            end else begin
                m = m8;  d = d8;  a = 64'(a8);  b = 64'(b8);  w = 8;
            end
            if (reset) begin
                pend[i] = 0; eres[i] = '0; eexc[i] = 1'b0; erdy[i] = 1'b0;
                model_ok = 1'b1;
            end else if (m ^ d) begin
                pend[i] = w + 1;
                model_op(d, a, b, w, pres[i], pexc[i]);
                erdy[i] = 1'b0;
            end else begin
                erdy[i] = 1'b0;
                if (pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) begin
                        erdy[i] = 1'b1;
                        eres[i] = pres[i];
                        eexc[i] = pexc[i];
                    end
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("dut32 busy",   64'(busy32), 64'(pend[0] > 0));
            chk("dut32 rdy",    64'(rdy32),  64'(erdy[0]));
            chk("dut32 result", 64'(r32),    eres[0]);
            chk("dut32 exc",    64'(e32),    64'(eexc[0]));
            chk("dut8 busy",    64'(busy8),  64'(pend[1] > 0));
            chk("dut8 rdy",     64'(rdy8),   64'(erdy[1]));
            chk("dut8 result",  64'(r8),     eres[1]);
            chk("dut8 exc",     64'(e8),     64'(eexc[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int i, input bit m, input bit d,
                         input logic [63:0] a, input logic [63:0] b);
        if (i == 0) begin
            m32 = m; d32 = d; a32 = a[31:0]; b32 = b[31:0];
        end else begin
            m8 = m; d8 = d; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    function automatic bit rdy_of(input int i);
        return (i == 0) ? rdy32 : rdy8;
    endfunction

    function automatic logic [63:0] res_of(input int i);
        return (i == 0) ? 64'(r32) : 64'(r8);
    endfunction

    function automatic bit exc_of(input int i);
        return (i == 0) ? e32 : e8;
    endfunction

    // Start an op at the current negedge and wait (bounded) for RDY; operands are
    // scrambled after the start edge to show they are not re-sampled.
    task automatic run_op(input int i, input bit is_div, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] er, input bit ee,
                          input string name);
        int w;
        int n;
        bit got;
        w   = (i == 0) ? 32 : 8;
        n   = 0;
        got = 1'b0;
        drive(i, !is_div, is_div, a, b);
        while (!got && n < w + 20) begin
            @(negedge clk);
            n++;
            if (n == 1) drive(i, 1'b0, 1'b0, ~a, ~b);
            if (rdy_of(i)) got = 1'b1;
        end
        chk({name, " latency"}, 64'(n), 64'(w + 2));
        chk({name, " result"}, res_of(i), er);
        chk({name, " exc"}, 64'(exc_of(i)), 64'(ee));
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        chk("reset result", 64'(r32), 64'd0);
        chk("reset busy", 64'(busy32), 64'd0);
        chk("reset rdy", 64'(rdy32), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back: each next start lands on the closing edge of the RDY cycle.
        run_op(0, 1'b0, 64'd7, 64'hFFFF_FFFA, 64'hFFFF_FFD6, 1'b0, "mul 7x-6");
        run_op(0, 1'b0, 64'h4000_0000, 64'd2, 64'h8000_0000, 1'b1, "mul ovf");
        run_op(0, 1'b0, 64'hFFFF_8000, 64'h0001_0000, 64'h8000_0000, 1'b0, "mul min");
        run_op(0, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 1'b0, "div -7/2");
        run_op(0, 1'b1, 64'd5, 64'd0, 64'd0, 1'b1, "div by 0");
        run_op(0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1'b1, "div min/-1");
        run_op(0, 1'b0, 64'd0, 64'hFFFF_FFFF, 64'd0, 1'b0, "mul 0x-1");

        // Abort: DIV started 8 edges after a MULT; only the DIV returns.
        drive(0, 1'b1, 1'b0, 64'd3, 64'd3);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (7) @(negedge clk);
        run_op(0, 1'b1, 64'd100, 64'd7, 64'd14, 1'b0, "abort div");

        // Start sampled on the DONE edge pre-empts the pending result.
        drive(0, 1'b1, 1'b0, 64'd2, 64'd3);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (32) @(negedge clk);
        run_op(0, 1'b1, 64'd9, 64'd3, 64'd3, 1'b0, "preempt div");

        // Both controls high: ignored.
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 1'b1, 64'd5, 64'd5);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        chk("both ctrl busy", 64'(busy32), 64'd0);
        @(negedge clk);

        // Reset mid-RUN clears everything and suppresses RDY.
        drive(0, 1'b1, 1'b0, 64'd9, 64'd9);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun reset busy", 64'(busy32), 64'd0);
        chk("midrun reset rdy", 64'(rdy32), 64'd0);
        chk("midrun reset result", 64'(r32), 64'd0);
        chk("midrun reset exc", 64'(e32), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // 8-bit instance.
        run_op(1, 1'b0, 64'h80, 64'h01, 64'h80, 1'b0, "w8 mul -128x1");
        run_op(1, 1'b1, 64'h7F, 64'h80, 64'h00, 1'b0, "w8 div 127/-128");
        run_op(1, 1'b0, 64'h10, 64'h08, 64'h80, 1'b1, "w8 mul ovf");
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
